// File: rtl/audio_out_pkg.sv
// Shared constants and types for the audio output FIFO: register byte addresses,
// playback state encoding and the default frame period.
package audio_out_pkg;

  localparam logic [31:0] ADDR_LEFT   = 32'h1000_0010;
  localparam logic [31:0] ADDR_RIGHT  = 32'h1000_0020;
  localparam logic [31:0] ADDR_STATUS = 32'h1000_0040;

  // 30 MHz clk / 44.1 kHz frame rate
  localparam int DEFAULT_TICKS_PER_SAMPLE = 680;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
// Push and pop in the same cycle are both honoured, including when full.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LVL_W-1:0] level_r;

  // storage array, no reset needed since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = (level_r == LVL_W'(DEPTH));
  assign empty    = (level_r == LVL_W'(0));
  assign level    = level_r;

endmodule

// File: rtl/audio_out_fifo.sv
// Wishbone-fed stereo sample FIFO that plays one frame every TICKS_PER_SAMPLE clocks.
// Optional statistics (underrun counter, orphan flag) enabled by AUDIO_OUT_STATS_EN.
module audio_out_fifo
  import audio_out_pkg::*;
#(
  parameter int DEPTH            = 64,
  parameter int TICKS_PER_SAMPLE = DEFAULT_TICKS_PER_SAMPLE,
  parameter int START_LEVEL      = 40,
  parameter int LOW_LEVEL        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_cyc,
  input  logic               wb_stb,
  input  logic               wb_we,
  input  logic [29:0]        wb_adr,
  input  logic [31:0]        wb_mosi,
  output logic [31:0]        wb_miso,
  output logic               wb_ack,
  output logic signed [15:0] out_left,
  output logic signed [15:0] out_right,
  output logic               out_strobe,
  output logic               nearly_empty
);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int TICK_W = (TICKS_PER_SAMPLE > 1) ? $clog2(TICKS_PER_SAMPLE) : 1;

  state_t              state_r, state_n;
  logic [TICK_W-1:0]   tick_r, tick_n;
  logic [15:0]         held_left_r;
  logic                left_pending_r;
  logic                stat_ack_r;
  logic [31:0]         wb_miso_r;
  logic signed [15:0]  out_left_r, out_right_r;
  logic                out_strobe_r;
  logic                nearly_empty_r;

  logic [31:0]         byte_adr_s;
  logic                sel_s, left_wr_s, right_wr_s, stat_rd_s, stat_cap_s;
  logic                wrap_s, pop_s, push_s;
  logic                fifo_full_s, fifo_empty_s;
  logic [LVL_W-1:0]    level_s;
  logic [31:0]         pop_data_s;
  logic [15:0]         underrun_cnt_s;
  logic                orphan_s;
  logic [31:0]         status_s;
  logic                unused_s;

  assign byte_adr_s = {wb_adr, 2'b00};
  assign sel_s      = wb_cyc & wb_stb;
  assign left_wr_s  = sel_s & wb_we  & (byte_adr_s == ADDR_LEFT);
  assign right_wr_s = sel_s & wb_we  & (byte_adr_s == ADDR_RIGHT);
  assign stat_rd_s  = sel_s & ~wb_we & (byte_adr_s == ADDR_STATUS);
  assign stat_cap_s = stat_rd_s & ~stat_ack_r;

  assign wrap_s = (state_r == PLAY) && (tick_r == TICK_W'(TICKS_PER_SAMPLE - 1));
  assign pop_s  = wrap_s & ~fifo_empty_s;
  // a stalled RIGHT write lands in the same cycle a pop frees its slot
  assign push_s = ~reset & right_wr_s & (~fifo_full_s | pop_s);
  assign wb_ack = ~reset & (left_wr_s | push_s | (stat_ack_r & stat_rd_s));

  assign unused_s = ^wb_mosi[31:16];

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data ({held_left_r, wb_mosi[15:0]}),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (level_s)
  );

  // playback state and frame tick register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FILL;
      tick_r  <= '0;
    end else begin
      state_r <= state_n;
      tick_r  <= tick_n;
    end
  end

  // next-state: fill until above START_LEVEL, fall back to FILL on underrun
  always_comb begin
    state_n = state_r;
    tick_n  = tick_r;
    case (state_r)
      FILL: begin
        tick_n = '0;
        if (level_s > LVL_W'(START_LEVEL)) state_n = PLAY;
        else                               state_n = FILL;
      end
      PLAY: begin
        if (wrap_s) begin
          tick_n = '0;
          if (fifo_empty_s) state_n = FILL;
          else              state_n = PLAY;
        end else begin
          tick_n = tick_r + TICK_W'(1);
        end
      end
      default: begin
        state_n = FILL;
        tick_n  = '0;
      end
    endcase
  end

  // bus-side holding register, status read pipeline and output frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_left_r    <= 16'd0;
      left_pending_r <= 1'b0;
      stat_ack_r     <= 1'b0;
      wb_miso_r      <= 32'd0;
      out_left_r     <= 16'sd0;
      out_right_r    <= 16'sd0;
      out_strobe_r   <= 1'b0;
      nearly_empty_r <= 1'b1;
    end else begin
      if (left_wr_s) begin
        held_left_r    <= wb_mosi[15:0];
        left_pending_r <= 1'b1;
      end else if (push_s) begin
        left_pending_r <= 1'b0;
      end
      stat_ack_r <= stat_cap_s;
      if (stat_cap_s) wb_miso_r <= status_s;
      out_strobe_r <= pop_s;
      if (pop_s) {out_left_r, out_right_r} <= pop_data_s;
      nearly_empty_r <= (level_s < LVL_W'(LOW_LEVEL));
    end
  end

`ifdef AUDIO_OUT_STATS_EN
  logic [15:0] underrun_cnt_r;
  logic        orphan_r;

  // saturating underrun counter and sticky orphan-RIGHT flag (cleared by STATUS read)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_cnt_r <= 16'd0;
      orphan_r       <= 1'b0;
    end else begin
      if (wrap_s && fifo_empty_s && (underrun_cnt_r != 16'hFFFF)) begin
        underrun_cnt_r <= underrun_cnt_r + 16'd1;
      end
      if (push_s && !left_pending_r) orphan_r <= 1'b1;
      else if (stat_cap_s)           orphan_r <= 1'b0;
    end
  end

  assign underrun_cnt_s = underrun_cnt_r;
  assign orphan_s       = orphan_r;
`else
  assign underrun_cnt_s = 16'd0;
  assign orphan_s       = 1'b0;
`endif

  assign status_s = {underrun_cnt_s, 4'd0, orphan_s, left_pending_r, nearly_empty_r,
                     (state_r == PLAY), 8'(level_s)};

  assign wb_miso      = wb_miso_r;
  assign out_left     = out_left_r;
  assign out_right    = out_right_r;
  assign out_strobe   = out_strobe_r;
  assign nearly_empty = nearly_empty_r;

endmodule

// File: tb/tb_audio_out_fifo.sv
// Scoreboard bench for audio_out_fifo: expected frames queued on RIGHT acks and
// compared on out_strobe; STATUS fields checked against a bench-side model.
module tb_audio_out_fifo;
  import audio_out_pkg::*;

  localparam int TICKS = DEFAULT_TICKS_PER_SAMPLE;
`ifdef AUDIO_OUT_STATS_EN
  localparam logic [31:0] STATS = 32'd1;
`else
  localparam logic [31:0] STATS = 32'd0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [29:0]        wb_adr = 30'd0;
  logic [31:0]        wb_mosi = 32'd0;
  logic [31:0]        wb_miso;
  logic               wb_ack;
  logic signed [15:0] out_left, out_right;
  logic               out_strobe;
  logic               nearly_empty;

  audio_out_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wb_cyc       (wb_cyc),
    .wb_stb       (wb_stb),
    .wb_we        (wb_we),
    .wb_adr       (wb_adr),
    .wb_mosi      (wb_mosi),
    .wb_miso      (wb_miso),
    .wb_ack       (wb_ack),
    .out_left     (out_left),
    .out_right    (out_right),
    .out_strobe   (out_strobe),
    .nearly_empty (nearly_empty)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          strobe_cnt = 0;
  logic [31:0] exp_q[$];
  logic [15:0] tb_held = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // scoreboard: every presented frame must match the oldest pushed pair
  always @(negedge clk) begin
    if (!reset && out_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) check("frame_unexpected", 32'd1, 32'd0);
      else check("frame", {out_left, out_right}, exp_q.pop_front());
    end
  end

  task automatic wb_write(input logic [31:0] addr, input logic [15:0] data);
    bit acked;
    acked = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = addr[31:2]; wb_mosi = {16'hDEAD, data};
    for (int i = 0; i < 2000 && !acked; i++) begin
      @(negedge clk);
      if (wb_ack) acked = 1'b1;
      @(posedge clk); #1;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (!acked) check("write_ack_timeout", 32'd0, 32'd1);
    else if (addr == ADDR_LEFT) tb_held = data;
    else if (addr == ADDR_RIGHT) exp_q.push_back({tb_held, data});
  endtask

  task automatic write_pair(input logic [15:0] l, input logic [15:0] r);
    wb_write(ADDR_LEFT, l);
    wb_write(ADDR_RIGHT, r);
  endtask

  task automatic wb_read_status(input string tag, input logic [31:0] exp);
    bit          acked;
    logic [31:0] data;
    acked = 1'b0;
    data = 32'd0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = ADDR_STATUS[31:2];
    for (int i = 0; i < 8 && !acked; i++) begin
      @(negedge clk);
      if (wb_ack) begin acked = 1'b1; data = wb_miso; end
      @(posedge clk); #1;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    if (!acked) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    else check(tag, data, exp);
  endtask

  task automatic apply_reset_and_check(input string tag);
    reset = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    tb_held = 16'd0;
    check({tag, "_outs"}, {out_left, out_right}, 32'd0);
    check({tag, "_ctl"}, {28'd0, out_strobe, wb_ack, nearly_empty, 1'b0}, 32'd2);
    check({tag, "_miso"}, wb_miso, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int acks;
    bit acked;

    // reset state
    repeat (2) @(posedge clk);
    apply_reset_and_check("reset1");
    wb_read_status("status_after_reset", 32'h0000_0200);

    // RIGHT without LEFT: pushes {0,R} and raises orphan until read
    wb_write(ADDR_RIGHT, 16'h3333);
    repeat (2) @(posedge clk); #1;
    wb_read_status("status_orphan", 32'h0000_0201 | (STATS << 11));
    wb_read_status("status_orphan_cleared", 32'h0000_0201);
    wb_write(ADDR_LEFT, 16'h4444);
    wb_read_status("status_left_pending", 32'h0000_0601);
    apply_reset_and_check("reset2");

    // 41 identical pairs start playback; first frame TICKS+1 cycles after last push
    for (int i = 0; i < 40; i++) write_pair(16'h1111, 16'h2222);
    repeat (2) @(posedge clk); #1;
    wb_read_status("status_level40", 32'h0000_0028);
    write_pair(16'h1111, 16'h2222);
    n = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (out_strobe) begin n = i; break; end
    end
    check("first_strobe_latency", 32'(n - 1), 32'(TICKS + 1));
    check("first_frame", {out_left, out_right}, 32'h1111_2222);
    @(posedge clk); #1;
    wb_read_status("status_playing", 32'h0000_0128);

    // drain all 41 frames, then underrun returns to FILL holding the last frame
    repeat (41 * TICKS + 20) @(posedge clk);
    @(negedge clk);
    check("strobe_count", 32'(strobe_cnt), 32'd41);
    check("held_frame", {out_left, out_right}, 32'h1111_2222);
    @(posedge clk); #1;
    wb_read_status("status_underrun", 32'h0000_0200 | (STATS << 16));

    // fill to capacity, then a 65th RIGHT write stalls until the first pop
    apply_reset_and_check("reset3");
    for (int i = 0; i < 64; i++) write_pair(16'h0100 + 16'(i), 16'h0200 + 16'(i));
    wb_write(ADDR_LEFT, 16'hAAAA);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = ADDR_RIGHT[31:2]; wb_mosi = 32'h0000_BBBB;
    n = 0; acked = 1'b0;
    for (int i = 0; i < 2000 && !acked; i++) begin
      @(negedge clk);
      if (wb_ack) acked = 1'b1;
      else n++;
      @(posedge clk); #1;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    check("stall_acked", 32'(acked), 32'd1);
    check("stall_long", 32'(n > 100), 32'd1);
    if (acked) exp_q.push_back({16'hAAAA, 16'hBBBB});
    @(negedge clk);
    check("strobe_after_stall_ack", 32'(out_strobe), 32'd1);
    @(posedge clk); #1;
    wb_read_status("status_full_after_swap", 32'h0000_0140);

    // reset during a stalled RIGHT write: no ack, reset outputs
    wb_write(ADDR_LEFT, 16'hCCCC);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = ADDR_RIGHT[31:2]; wb_mosi = 32'h0000_DDDD;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wb_ack) acks++;
    end
    check("stalled_no_ack", 32'(acks), 32'd0);
    reset = 1'b1;
    #1;
    check("ack_during_reset", 32'(wb_ack), 32'd0);
    apply_reset_and_check("reset_mid_stall");
    wb_read_status("status_after_stall_reset", 32'h0000_0200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
